// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with frame-based debounce and a 4-digit decimal entry accumulator.
// Output cnt/valid plug straight into the seven-segment display driver.
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 25000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [13:0] cnt,
  output logic        valid,
  output logic [2:0]  digits,
  output logic        key_strb,
  output logic [3:0]  key_code
);

  localparam int unsigned DivW     = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [3:0] DbTarget  = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StConfirm, StHeld, StRelease} state_e;

  logic [3:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      col_idx_q;
  logic [1:0]      hits_q;
  logic [3:0]      code_q;
  state_e          state_q, state_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [13:0]     cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [2:0]      digits_q, digits_d;
  logic            strb_q;
  logic [3:0]      key_code_q, key_code_d;

  logic            div_last, frame_end, frame_key, accept;
  logic [3:0]      row_low;
  logic [2:0]      n_low, hit_sum;
  logic [1:0]      hits_next;
  logic [3:0]      code_next;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [3:0] low);
    logic [1:0] r;
    r = 2'd0;
    case (low)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    case ({c, r})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h4;
      4'h2: key_map = 4'h7;
      4'h3: key_map = 4'h0;
      4'h4: key_map = 4'h2;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h8;
      4'h7: key_map = 4'hF;
      4'h8: key_map = 4'h3;
      4'h9: key_map = 4'h6;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hE;
      4'hC: key_map = 4'hA;
      4'hD: key_map = 4'hB;
      4'hE: key_map = 4'hC;
      default: key_map = 4'hD;
    endcase
  endfunction

  // Row synchroniser; resets to "no key" so the first frame reads idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign div_last  = (div_q == DivLast);
  assign frame_end = div_last && (col_idx_q == 2'd3);
  assign col       = ~(4'b0001 << col_idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
    end else if (div_last) begin
      div_q     <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  // Low-row bits are counted across the whole frame, saturating at 2 (MULTI).
  always_comb begin
    row_low   = ~row_sync_q;
    n_low     = {2'b0, row_low[0]} + {2'b0, row_low[1]} + {2'b0, row_low[2]} +
                {2'b0, row_low[3]};
    hit_sum   = {1'b0, hits_q} + n_low;
    hits_next = hits_q;
    code_next = code_q;
    if (div_last) begin
      hits_next = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      if (n_low == 3'd1) code_next = key_map(col_idx_q, row_low);
    end
    frame_key = frame_end && (hits_next == 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= 2'd0;
      code_q <= 4'd0;
    end else if (frame_end) begin
      hits_q <= 2'd0;
      code_q <= 4'd0;
    end else begin
      hits_q <= hits_next;
      code_q <= code_next;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (frame_end) begin
      case (state_q)
        StIdle: begin
          if (frame_key) begin
            cand_d = code_next;
            dcnt_d = 4'd1;
            if (DbTarget <= 4'd1) begin
              accept  = 1'b1;
              state_d = StHeld;
            end else begin
              state_d = StConfirm;
            end
          end
        end
        StConfirm: begin
          if (frame_key && (code_next == cand_q)) begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_d >= DbTarget) begin
              accept  = 1'b1;
              state_d = StHeld;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (!frame_key) begin
            dcnt_d  = 4'd1;
            state_d = (DbTarget <= 4'd1) ? StIdle : StRelease;
          end
        end
        StRelease: begin
          if (frame_key) begin
            state_d = StHeld;
          end else begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_d >= DbTarget) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    digits_d   = digits_q;
    key_code_d = key_code_q;
    if (accept) begin
      key_code_d = code_next;
      if (code_next <= 4'd9) begin
        if (valid_q) begin
          cnt_d    = {10'd0, code_next};
          digits_d = 3'd1;
          valid_d  = 1'b0;
        end else if (digits_q < 3'd4) begin
          // cnt*10 + d; at most 999*10+9, so 14 bits never overflow.
          cnt_d    = {cnt_q[10:0], 3'b000} + {cnt_q[12:0], 1'b0} + {10'd0, code_next};
          digits_d = digits_q + 3'd1;
        end
      end else if (code_next == 4'hE) begin
        valid_d = 1'b1;
      end else if (code_next == 4'hC) begin
        cnt_d    = 14'd0;
        digits_d = 3'd0;
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dcnt_q     <= 4'd0;
      cand_q     <= 4'd0;
      cnt_q      <= 14'd0;
      valid_q    <= 1'b0;
      digits_q   <= 3'd0;
      strb_q     <= 1'b0;
      key_code_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      digits_q   <= digits_d;
      strb_q     <= accept;
      key_code_q <= key_code_d;
    end
  end

  assign cnt      = cnt_q;
  assign valid    = valid_q;
  assign digits   = digits_q;
  assign key_strb = strb_q;
  assign key_code = key_code_q;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Front-panel numeric entry block; the input-side counterpart of the multiplexed seven-segment display driver.
- Scans a 4x4 matrix keypad (Pmod KYPD layout) with active-low column drives and samples the active-low rows.
- Debounces key presses and accumulates decimal keystrokes into an unsigned binary count in [0,9999].
- Its cnt output feeds the display driver's 14-bit count input directly; its valid output feeds the display driver's valid input.

Parameters:
- SCAN_DIV, 25000: clk cycles each column is driven before the rows are sampled. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical scan frames required to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col  output  4  keypad column drive, active-low, exactly one bit low at a time.
- cnt  output  14  accumulated binary value, [0,9999].
- valid  output  1  1 = entry committed with E; 0 = entry in progress or cleared.
- digits  output  3  number of digits entered, 0..4.
- key_strb  output  1  one-clock pulse per accepted key press.
- key_code  output  4  code of the last accepted key, held between strobes.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): col=4'b1110, cnt=0, valid=0, digits=0, key_strb=0, key_code=0. Scan counter, column index, debounce FSM and sync flops all clear.
- Row synchroniser: row passes through 2 flops before any use.
- Scan: column index k cycles 0,1,2,3,0,...; col = ~(1<<k).
  - Each column is held SCAN_DIV clocks.
  - Synchronised rows are sampled on the last clock of the slot.
  - One frame = 4*SCAN_DIV clocks.
- Key map (column, row) -> code:
  - col0: rows 0..3 = 1,4,7,0
  - col1: rows 0..3 = 2,5,8,F
  - col2: rows 0..3 = 3,6,9,E
  - col3: rows 0..3 = A,B,C,D
- Frame result, latched at frame end:
  - NONE: zero low rows seen in the frame.
  - KEY(code): exactly one low row bit seen across the whole frame.
  - MULTI: two or more low row bits seen; MULTI is treated as NONE for acceptance.
- Debounce FSM, with counter dcnt:
  - IDLE: on KEY(c), set cand=c, dcnt=1, go to CONFIRM.
  - CONFIRM: on KEY(cand), increment dcnt. When dcnt reaches DEBOUNCE_SCANS, go to HELD and issue an accept. Any other result returns to IDLE.
  - HELD: on NONE/MULTI, set dcnt=1 and go to RELEASE. On KEY(any), stay in HELD; no repeat accepts.
  - RELEASE: on NONE/MULTI, increment dcnt; at DEBOUNCE_SCANS go to IDLE. On KEY(any), return to HELD.
  - With DEBOUNCE_SCANS=1, the accept occurs on the first KEY frame.
- Accept: key_strb=1 for exactly one clk, in the cycle after the frame end that completes debounce.
  - key_code, cnt, valid and digits update in that same cycle.
- Entry update on accept (registered):
  - Digit d (0..9), valid=1: cnt=d, digits=1, valid=0 (starts a new entry).
  - Digit d, valid=0, digits<4: cnt=cnt*10+d, computed as (cnt<<3)+(cnt<<1)+d in 14 bits, no overflow since the maximum is 9999; digits+1.
  - Digit d, valid=0, digits=4: ignored; cnt and digits unchanged.
  - E: valid=1; cnt and digits held. E with digits=0 gives cnt=0, valid=1.
  - C: cnt=0, digits=0, valid=0.
  - A, B, D, F: key_strb and key_code still update; the entry state is unchanged.
- The scan runs continuously, independent of the debounce state.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame = 16 clk):
1. Reset: drive rst_n=0 mid-frame during a held key -> all outputs reset immediately, col=1110. Release rst_n with the key still held -> exactly one key_strb after 2 frames.
2. Press 1,2,3,4 (each held 3 frames, released 3 frames), then E -> cnt steps 1,12,123,1234; digits steps 1..4; then valid=1; exactly 5 key_strb pulses total.
3. After test 2, press 5 -> cnt=5, digits=1, valid=0. Then press 6,7,8,9 -> cnt=5678 after 6,7,8 and stays 5678 after 9; digits=4.
4. Press 7 present for 1 frame only, then bouncing released/pressed every other frame -> no key_strb, cnt unchanged.
5. Hold 2 and 6 simultaneously for 5 frames -> no key_strb. Hold 9 for 20 frames -> exactly one key_strb, key_code=9.
6. Enter 42, press C -> cnt=0, digits=0, valid=0. Press E -> valid=1, cnt=0. Press D -> key_strb=1, key_code=D, cnt/valid/digits unchanged.
